key_word_window: RTL

//  Parametrised NK-word sliding window for the AES key-expansion datapath (AES-128/192/256).

---
 rtl/key_word_window.sv | 138 +++++++++++++
 1 files changed

// File: rtl/key_word_window.sv
// NK-word sliding window over the AES key schedule: holds w[i-NK]..w[i-1], word index, phase and Rcon.
// Optional feature KEY_RELOAD_EN: a reload input restarts expansion from a shadow copy of the last loaded key.
module key_word_window #(
  parameter int NK     = 4,
  parameter int WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ld,
  input  logic [NK*WORD_W-1:0] key,
  input  logic                 wr_en,
  input  logic [WORD_W-1:0]    word_in,
`ifdef KEY_RELOAD_EN
  input  logic                 reload,
`endif
  output logic [WORD_W-1:0]    word_0,
  output logic [WORD_W-1:0]    word_last,
  output logic [5:0]           word_idx,
  output logic                 sub_req,
  output logic                 sub_only,
  output logic [7:0]           rcon,
  output logic                 busy,
  output logic                 done
);

  localparam int         TOTAL      = 4 * (NK + 7);
  localparam logic [5:0] LAST_IDX   = 6'(TOTAL - 1);
  localparam logic [5:0] FIRST_IDX  = 6'(NK);
  localparam logic [2:0] LAST_PHASE = 3'(NK - 1);

  generate
    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
      $error("key_word_window: NK must be 4, 6 or 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [WORD_W-1:0]    window [NK];
  logic [5:0]           idx;
  logic [2:0]           phase;
  logic [7:0]           rcon_q;
  logic                 start;
  logic                 shift;
  logic [NK*WORD_W-1:0] start_key;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

`ifdef KEY_RELOAD_EN
  logic [NK*WORD_W-1:0] shadow_key;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_key <= '0;
    end else if (ld) begin
      shadow_key <= key;
    end
  end
`endif

  // A load (or reload) restarts the schedule from any state and takes precedence over a write.
  always_comb begin
    start      = ld;
    start_key  = key;
    shift      = 1'b0;
    state_next = state;
`ifdef KEY_RELOAD_EN
    if (!ld && reload) begin
      start     = 1'b1;
      start_key = shadow_key;
    end
`endif
    if (start) begin
      state_next = RUN;
    end else if (state == RUN && wr_en) begin
      shift = 1'b1;
      if (idx == LAST_IDX) begin
        state_next = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // window[0] is the oldest word; the key MSW lands there so it becomes w[0].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < NK; j++) begin
        window[j] <= '0;
      end
      idx    <= '0;
      phase  <= '0;
      rcon_q <= '0;
    end else if (start) begin
      for (int j = 0; j < NK; j++) begin
        window[j] <= start_key[(NK-1-j)*WORD_W +: WORD_W];
      end
      idx    <= FIRST_IDX;
      phase  <= '0;
      rcon_q <= 8'h01;
    end else if (shift) begin
      for (int j = 0; j < NK - 1; j++) begin
        window[j] <= window[j+1];
      end
      window[NK-1] <= word_in;
      idx          <= idx + 6'd1;
      phase        <= (phase == LAST_PHASE) ? 3'd0 : phase + 3'd1;
      if (phase == 3'd0) begin
        rcon_q <= xtime(rcon_q);
      end
    end
  end

  assign word_0    = window[0];
  assign word_last = window[NK-1];
  assign word_idx  = idx;
  assign rcon      = rcon_q;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign sub_req   = busy && (phase == 3'd0);
  assign sub_only  = (NK == 8) && busy && (phase == 3'd4);

endmodule
